// File: rtl/scrambler.sv
`timescale 1ns/100ps
// scrambler: bit-serial 802.11a scrambler/descrambler, PRBS S(x) = x^7 + x^4 + 1
//   clk            rising-edge system clock
//   reset          asynchronous active-low reset, loads SEED and clears the output
//   data           serial input bit, one per clock
//   scrambled_data registered output, data XOR PRBS bit
module scrambler #(
  parameter logic [6:0] SEED = 7'b1111111
) (
  input  logic clk,
  input  logic reset,
  input  logic data,
  output logic scrambled_data
);
  logic [6:0] s;
  logic fb;
  assign fb = s[6] ^ s[3];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s <= SEED;
      scrambled_data <= 1'b0;
    end else begin
      s <= {s[5:0], fb};
      scrambled_data <= data ^ fb;
    end
endmodule

// File: tb/tb_scrambler.sv
`timescale 1ns/100ps
// tb_scrambler: scoreboard bench for scrambler, default seed, alternate seed and a descrambling cascade
module tb_scrambler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic data = 1'b0;
  logic r1;
  logic o0, o1, o2;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic c0, e0, c1, e1, c2, e2;
    int tst, idx;
  } ent_t;
  ent_t q[$];
  logic [63:0] K = 64'h0EF2C902262EB60C;
  logic [6:0] K2 = 7'b0110110;
  logic p[127];
  always #10 clk = ~clk;
  // the descrambler comes out of reset one clock later so its PRBS lines up with the bit it receives
  always @(posedge clk or negedge reset)
    if (!reset) r1 <= 1'b0;
    else r1 <= 1'b1;
  scrambler u0 (.clk(clk), .reset(reset), .data(data), .scrambled_data(o0));
  scrambler u1 (.clk(clk), .reset(r1), .data(o0), .scrambled_data(o1));
  scrambler #(.SEED(7'b1011101)) u2 (.clk(clk), .reset(reset), .data(1'b0), .scrambled_data(o2));
  function automatic logic e(int i);
    int k = i % 127;
    return (k < 64) ? K[63-k] : p[k];
  endfunction
  task automatic push(input logic d, c0, e0, c1, e1, c2, e2, input int tst, idx);
    data = d;
    q.push_back('{c0, e0, c1, e1, c2, e2, tst, idx});
    @(negedge clk);
  endtask
  task automatic rst_cycle(input int tst);
    reset = 1'b0;
    push(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, tst, -1);
    reset = 1'b1;
  endtask
  initial begin
    ent_t t;
    forever begin
      @(posedge clk);
      #5;
      if (q.size() > 0) begin
        t = q.pop_front();
        if (t.c0) begin
          checks++;
          if (o0 !== t.e0) begin
            errors++;
            $display("FAIL out0 test%0d bit%0d: got %b expected %b", t.tst, t.idx, o0, t.e0);
          end
        end
        if (t.c1) begin
          checks++;
          if (o1 !== t.e1) begin
            errors++;
            $display("FAIL cascade test%0d bit%0d: got %b expected %b", t.tst, t.idx, o1, t.e1);
          end
        end
        if (t.c2) begin
          checks++;
          if (o2 !== t.e2) begin
            errors++;
            $display("FAIL seed2 test%0d bit%0d: got %b expected %b", t.tst, t.idx, o2, t.e2);
          end
        end
      end
    end
  end
  initial begin
    logic [6:0] m;
    logic d, prev;
    m = 7'b1111111;
    for (int i = 0; i < 127; i++) begin
      p[i] = m[6] ^ m[3];
      m = {m[5:0], m[6] ^ m[3]};
    end
    @(negedge clk);
    rst_cycle(1);
    for (int i = 0; i < 135; i++)
      push(1'b0, 1'b1, e(i), 1'b0, 1'b0, (i < 7) || (i >= 127 && i < 134), K2[6 - (i % 127)], 1, i);
    rst_cycle(2);
    for (int i = 0; i < 64; i++)
      push(1'b1, 1'b1, ~e(i), 1'b0, 1'b0, 1'b0, 1'b0, 2, i);
    rst_cycle(3);
    for (int i = 0; i < 49; i++)
      push(1'b0, 1'b1, e(i), 1'b0, 1'b0, 1'b0, 1'b0, 3, i);
    #1 reset = 1'b0;
    #0.5;
    checks++;
    if (o0 !== 1'b0 || o2 !== 1'b0) begin
      errors++;
      $display("FAIL pulse_reset: got %b%b expected 00", o0, o2);
    end
    #0.5 reset = 1'b1;
    for (int i = 0; i < 8; i++)
      push(1'b0, 1'b1, e(i), 1'b0, 1'b0, 1'b0, 1'b0, 4, i);
    rst_cycle(5);
    prev = 1'b0;
    for (int j = 0; j < 1000; j++) begin
      d = 1'($urandom_range(0, 1));
      push(d, 1'b1, d ^ e(j), 1'b1, prev, 1'b0, 1'b0, 5, j);
      prev = d;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
